clk_rate_scheduler: RTL
=======================

CLK_RATE_SCHEDULER -- requirements
Module: clk_rate_scheduler

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of monitored test clocks (2..16).
REQ-002 SHALL have parameter WINDOW, default 1000000, clk100 cycles the counter gate is open.
REQ-003 SHALL have parameter SETTLE, default 16, clk100 cycles after a mux change before clearing.
REQ-004 SHALL have parameter CLR_CYC, default 8, clk100 cycles meas_clr is held.
REQ-005 SHALL have parameter HOLD, default 64, clk100 cycles after gate close before sampling the count.
REQ-006 SHALL have port clk100  in  1  100 MHz reference and control clock.
REQ-007 SHALL have port async_reset_clktest  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  in  1  one-cycle pulse that begins a sweep.
REQ-009 SHALL have port abort  in  1  level; stops any sweep.
REQ-010 SHALL have port continuous  in  1  restarts the sweep after the last channel.
REQ-011 SHALL have port ch_enable  in  N_CH  per-channel measurement enable.
REQ-012 SHALL have port meas_sel  out  clog2(N_CH)  test-clock mux select.
REQ-013 SHALL have port meas_clr  out  1  clears the shared rate counter.
REQ-014 SHALL have port meas_arm  out  1  counter gate.
REQ-015 SHALL have port meas_count  in  24  stable count from the shared counter.
REQ-016 SHALL have port result_ch  out  clog2(N_CH)  channel of the current result.
REQ-017 SHALL have port result_value  out  32  zero-extended count.
REQ-018 SHALL have port result_valid  out  1  one-cycle strobe.
REQ-019 SHALL have port busy  out  1  high when the state is not IDLE.
REQ-020 SHALL have port done  out  1  one-cycle strobe at sweep end.
REQ-021 SHALL have port dead_clk  out  N_CH  sticky flag; the last count was 0.

Function
REQ-022 SHALL have states IDLE, SELECT, CLEAR, COUNT, WAIT, CAPTURE, NEXT.
REQ-023 SHALL, in IDLE, on start with any ch_enable bit set, load the lowest enabled index into meas_sel and enter SELECT.
REQ-024 SHALL, on start with ch_enable==0, stay in IDLE and pulse done one cycle later.
REQ-025 SHALL hold SELECT for SETTLE cycles, CLEAR (meas_clr=1) for CLR_CYC cycles, COUNT (meas_arm=1) for exactly WINDOW cycles, and WAIT for HOLD cycles.
REQ-026 SHALL, in CAPTURE (1 cycle), register result_value={8'h0,meas_count} and result_ch=meas_sel, pulse result_valid the next cycle, and set or clear dead_clk[meas_sel] according to whether meas_count==0.
REQ-027 SHALL, in NEXT, select the next enabled index above meas_sel using ch_enable sampled that cycle and enter SELECT; if no higher index is enabled, pulse done and enter IDLE, or wrap to the lowest enabled index when continuous=1.
REQ-028 SHALL make the per-channel latency from SELECT entry to result_valid equal to SETTLE+CLR_CYC+WINDOW+HOLD+2 cycles.
REQ-029 SHALL, when abort=1 in any state, enter IDLE on the next cycle with meas_arm=0 and meas_clr=1 for one cycle, and SHALL NOT pulse result_valid or done.
REQ-030 SHALL ignore start while busy=1, and SHALL give abort priority when start and abort are simultaneous.
REQ-031 SHALL hold result_value unchanged between result_valid strobes.

Reset
REQ-032 SHALL, while async_reset_clktest=1, hold state=IDLE, meas_sel=0, meas_clr=1, meas_arm=0, result_value=32'hFFFFFFFF, result_ch=0, result_valid=0, busy=0, done=0, dead_clk=0, and all timers at 0.
REQ-033 SHALL, when reset is asserted mid-COUNT, drop meas_arm asynchronously and discard the partial measurement.

Configuration
REQ-034 SHALL, with CLK_RATE_SCHED_LIMIT_EN defined, add inputs lim_lo[23:0] and lim_hi[23:0] and output rate_alarm[N_CH], where the CAPTURE of channel c sets rate_alarm[c]=1 if count<lim_lo or count>lim_hi and sets it to 0 otherwise, with a reset value of 0.
REQ-035 SHALL, without CLK_RATE_SCHED_LIMIT_EN, omit those ports and the comparison logic entirely.

Structure
REQ-036 SHALL place the state enum, the COUNT_W=24 and RESULT_W=32 constants, and the parameter defaults in the package clk_rate_pkg.
REQ-037 SHALL implement the next-enabled-channel search (priority find above index, with wrap) as the sub-module clk_rate_ch_picker.

Verification
REQ-038 SHALL cover: WINDOW=100, SETTLE=4, CLR_CYC=2, HOLD=8, ch_enable=4'b1011, meas_count model=channel*10+5 -> result_valid for ch0 (5), ch1 (15), ch3 (35), 116 cycles apart, then done.
REQ-039 SHALL cover: ch_enable=0, start -> done one cycle later, busy never high.
REQ-040 SHALL cover: channel 2 meas_count=0 -> dead_clk[2]=1; next sweep with count 7 -> dead_clk[2]=0.
REQ-041 SHALL cover: abort at COUNT cycle 50 -> IDLE next cycle, meas_arm=0, no result_valid.
REQ-042 SHALL cover: continuous=1, ch_enable=4'b1000 -> ch3 measured repeatedly, done never pulses.
REQ-043 SHALL cover: CLK_RATE_SCHED_LIMIT_EN defined, lim_lo=10, lim_hi=20, count 25 -> rate_alarm set; count 15 -> rate_alarm cleared.

Source files
------------

// File: rtl/clk_rate_pkg.sv
// Shared types and constants for the clock-rate measurement scheduler.
// Holds the sequencer state encoding, datapath widths and parameter defaults.
package clk_rate_pkg;

  localparam int COUNT_W  = 24;
  localparam int RESULT_W = 32;
  localparam int TMR_W    = 32;

  localparam int N_CH_DEF    = 4;
  localparam int WINDOW_DEF  = 1000000;
  localparam int SETTLE_DEF  = 16;
  localparam int CLR_CYC_DEF = 8;
  localparam int HOLD_DEF    = 64;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    CLEAR,
    COUNT,
    WAIT,
    CAPTURE,
    NEXT
  } sched_state_t;

  // Terminal timer value for a phase lasting n cycles.
  function automatic logic [TMR_W-1:0] last_tick(input int n);
    return TMR_W'(n - 1);
  endfunction

endpackage

// File: rtl/clk_rate_ch_picker.sv
// Channel search: lowest enabled channel, and the next enabled channel above cur
// (falling back to the lowest one when wrap is set).
module clk_rate_ch_picker #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  enable,
  input  logic [SEL_W-1:0] cur,
  input  logic             wrap,
  output logic [SEL_W-1:0] first_sel,
  output logic             any_en,
  output logic [SEL_W-1:0] next_sel,
  output logic             next_found
);

  logic [N_CH-1:0]  above_mask;
  logic [SEL_W-1:0] above_sel;
  logic             above_found;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_above
    assign above_mask[gi] = enable[gi] && (SEL_W'(gi) > cur);
  end

  // Scanning downward lets the lowest matching index win.
  always_comb begin
    first_sel   = '0;
    any_en      = 1'b0;
    above_sel   = '0;
    above_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (enable[i]) begin
        first_sel = SEL_W'(i);
        any_en    = 1'b1;
      end
      if (above_mask[i]) begin
        above_sel   = SEL_W'(i);
        above_found = 1'b1;
      end
    end
  end

  assign next_found = above_found || (wrap && any_en);
  assign next_sel   = above_found ? above_sel : first_sel;

endmodule

// File: rtl/clk_rate_scheduler.sv
// Sweeps enabled test clocks through a shared rate counter and reports counts.
// Optional range alarms are built when CLK_RATE_SCHED_LIMIT_EN is defined.
module clk_rate_scheduler
  import clk_rate_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int WINDOW  = WINDOW_DEF,
  parameter int SETTLE  = SETTLE_DEF,
  parameter int CLR_CYC = CLR_CYC_DEF,
  parameter int HOLD    = HOLD_DEF
) (
  input  logic                    clk100,
  input  logic                    async_reset_clktest,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    continuous,
  input  logic [N_CH-1:0]         ch_enable,
  output logic [$clog2(N_CH)-1:0] meas_sel,
  output logic                    meas_clr,
  output logic                    meas_arm,
  input  logic [COUNT_W-1:0]      meas_count,
  output logic [$clog2(N_CH)-1:0] result_ch,
  output logic [RESULT_W-1:0]     result_value,
  output logic                    result_valid,
  output logic                    busy,
  output logic                    done,
  output logic [N_CH-1:0]         dead_clk
`ifdef CLK_RATE_SCHED_LIMIT_EN
  ,
  input  logic [COUNT_W-1:0]      lim_lo,
  input  logic [COUNT_W-1:0]      lim_hi,
  output logic [N_CH-1:0]         rate_alarm
`endif
);

  localparam int SEL_W = $clog2(N_CH);

  sched_state_t     state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next, phase_last;
  logic             phase_end;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic             done_reg, done_next;
  logic             clr_pulse_reg, clr_pulse_next;
  logic             capture_en, cap_d_reg, result_valid_reg;
  logic [COUNT_W-1:0]  cap_value_reg;
  logic [SEL_W-1:0]    cap_ch_reg;
  logic [RESULT_W-1:0] result_value_reg;
  logic [SEL_W-1:0]    result_ch_reg;
  logic [N_CH-1:0]     dead_clk_reg;
  logic [SEL_W-1:0]    first_sel, next_sel;
  logic                any_en, next_found;

  clk_rate_ch_picker #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_picker (
    .enable     (ch_enable),
    .cur        (sel_reg),
    .wrap       (continuous),
    .first_sel  (first_sel),
    .any_en     (any_en),
    .next_sel   (next_sel),
    .next_found (next_found)
  );

  always_comb begin
    phase_last = '0;
    case (state_reg)
      SELECT:  phase_last = last_tick(SETTLE);
      CLEAR:   phase_last = last_tick(CLR_CYC);
      COUNT:   phase_last = last_tick(WINDOW);
      WAIT:    phase_last = last_tick(HOLD);
      default: phase_last = '0;
    endcase
  end

  assign phase_end = (timer_reg == phase_last);

  // Timer restarts from zero on every state change since it defaults to 0.
  always_comb begin
    state_next     = state_reg;
    timer_next     = '0;
    sel_next       = sel_reg;
    done_next      = 1'b0;
    clr_pulse_next = 1'b0;
    capture_en     = 1'b0;
    if (abort) begin
      state_next     = IDLE;
      clr_pulse_next = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (any_en) begin
              sel_next   = first_sel;
              state_next = SELECT;
            end else begin
              done_next = 1'b1;
            end
          end
        end
        SELECT:  if (phase_end) state_next = CLEAR;   else timer_next = timer_reg + 1;
        CLEAR:   if (phase_end) state_next = COUNT;   else timer_next = timer_reg + 1;
        COUNT:   if (phase_end) state_next = WAIT;    else timer_next = timer_reg + 1;
        WAIT:    if (phase_end) state_next = CAPTURE; else timer_next = timer_reg + 1;
        CAPTURE: begin
          capture_en = 1'b1;
          state_next = NEXT;
        end
        NEXT: begin
          if (next_found) begin
            sel_next   = next_sel;
            state_next = SELECT;
          end else begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk100 or posedge async_reset_clktest) begin
    if (async_reset_clktest) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      sel_reg       <= '0;
      done_reg      <= 1'b0;
      clr_pulse_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      sel_reg       <= sel_next;
      done_reg      <= done_next;
      clr_pulse_reg <= clr_pulse_next;
    end
  end

  // Count is staged at CAPTURE and published together with the strobe.
  always_ff @(posedge clk100 or posedge async_reset_clktest) begin
    if (async_reset_clktest) begin
      cap_d_reg        <= 1'b0;
      cap_value_reg    <= '0;
      cap_ch_reg       <= '0;
      result_valid_reg <= 1'b0;
      result_value_reg <= '1;
      result_ch_reg    <= '0;
      dead_clk_reg     <= '0;
    end else begin
      cap_d_reg        <= capture_en;
      result_valid_reg <= cap_d_reg && !abort;
      if (capture_en) begin
        cap_value_reg         <= meas_count;
        cap_ch_reg            <= sel_reg;
        dead_clk_reg[sel_reg] <= (meas_count == '0);
      end
      if (cap_d_reg && !abort) begin
        result_value_reg <= {{(RESULT_W-COUNT_W){1'b0}}, cap_value_reg};
        result_ch_reg    <= cap_ch_reg;
      end
    end
  end

`ifdef CLK_RATE_SCHED_LIMIT_EN
  logic [N_CH-1:0] rate_alarm_reg;

  always_ff @(posedge clk100 or posedge async_reset_clktest) begin
    if (async_reset_clktest) begin
      rate_alarm_reg <= '0;
    end else if (capture_en) begin
      rate_alarm_reg[sel_reg] <= (meas_count < lim_lo) || (meas_count > lim_hi);
    end
  end

  assign rate_alarm = rate_alarm_reg;
`endif

  assign meas_sel     = sel_reg;
  assign meas_clr     = clr_pulse_reg || (state_reg == CLEAR);
  assign meas_arm     = (state_reg == COUNT);
  assign result_ch    = result_ch_reg;
  assign result_value = result_value_reg;
  assign result_valid = result_valid_reg;
  assign busy         = (state_reg != IDLE);
  assign done         = done_reg;
  assign dead_clk     = dead_clk_reg;

endmodule
